ps2_key_event_queue: RTL and testbench
======================================

// Module: ps2_key_event_queue
// PURPOSE
//  Parametrised successor to the single-slot keyboard decoder. Consumes the PS/2 byte stream from
//  ps2_keyboard (data/ready/nextdata_n) and decodes E0/F0/E1 prefixes into key events.
//  Tracks held keys, modifiers and lock toggles, and queues {repeat,break,e0,code} events in a FIFO.
//  Sits between ps2_keyboard and the console/audio consumers, replacing single-cycle newKey strobes.
// PARAMETERS
//  DEPTH        16  event FIFO entries; power of two, 2..256
//  EMIT_REPEAT  1   1: typematic repeats of held keys are queued; 0: they are dropped
//  PAUSE_SKIP   7   bytes swallowed after an E1 prefix (Pause key)
// PORTS
//  clk          in   1   system clock
//  clr          in   1   synchronous active-high reset
//  kb_data      in   8   byte from ps2_keyboard
//  kb_ready     in   1   ps2_keyboard holds a byte
//  kb_nextdata_n out 1   active-low one-cycle "byte consumed" strobe to ps2_keyboard
//  ev_data      out  11  head event {repeat, brk, e0, code[7:0]}
//  ev_valid     out  1   FIFO non-empty
//  ev_ready     in   1   consumer pops head when ev_valid & ev_ready
//  ev_count     out  $clog2(DEPTH)+1  entries queued
//  ovf          out  1   sticky: an event was dropped because the FIFO was full
//  ovf_clr      in   1   clears ovf
//  shift/ctrl/alt out 1 each  live modifier state (L|R; ctrl/alt include E0 variants)
//  caps/num/scroll out 1 each lock flags
//  held_cnt     out  9   number of keys currently held (plain + E0 tables)
// BEHAVIOUR
//  Clock/reset: single clock, reset is synchronous and active-high on clr. On reset: FSM=IDLE, all
//   outputs 0 (kb_nextdata_n=1). Key tables, FIFO pointers and locks clear. Reset mid-sequence
//   discards partial prefixes and queued events.
//  Byte handshake: a byte is consumed in a cycle where kb_ready=1 and kb_nextdata_n=1.
//   kb_nextdata_n is then 0 for exactly the next cycle. kb_ready is ignored while it is 0, so there
//   are at most one byte per 2 cycles.
//  Prefix FSM (states IDLE, E0, F0, E0F0, SKIP):
//   IDLE: E0->E0; F0->F0; E1->SKIP (cnt=PAUSE_SKIP); 00/AA/FA/FE/FF ignored; other -> make(e0=0).
//   E0: F0->E0F0; E0->E0 (extra E0 swallowed); E1/FA/AA -> IDLE; other -> make(e0=1) -> IDLE.
//   F0: other -> break(e0=0) -> IDLE. E0F0: other -> break(e0=1) -> IDLE.
//   A prefix byte in F0/E0F0 returns to IDLE with no event.
//   SKIP: decrement per consumed byte; on last byte emit make {0,0,1,8'h7E} (Pause) -> IDLE.
//  Key tables: 256-bit plain + 256-bit E0 bitmaps.
//   make: bit clear -> set bit, held_cnt+1, push {0,0,e0,code}.
//   make: bit set -> repeat; push {1,0,e0,code} only if EMIT_REPEAT.
//   break: bit set -> clear, held_cnt-1, push {0,1,e0,code}.
//   break: bit clear -> push break, no count change (held_cnt never wraps below 0).
//   Pause never sets a table bit.
//  Locks toggle on a non-repeat make only: 58 caps, 77 num (plain), 7E scroll (plain).
//  Modifiers: shift=plain[12]|plain[59]; ctrl=plain[14]|e0[14]; alt=plain[11]|e0[11].
//   All table effects are visible the cycle after the byte is consumed.
//  FIFO: first-word-fall-through; ev_data valid whenever ev_valid. A push is visible on ev_valid one
//   cycle after byte consumption.
//   Full with no pop: event dropped, ovf set; table/lock updates still occur.
//   Full with pop in same cycle: push accepted, count unchanged.
//   Empty: a pop has no effect. Pointers wrap mod DEPTH.
//   ovf_clr and a same-cycle drop: ovf stays 1 (set wins).
// TESTING
//  1 Bytes 1C, F0 1C -> events 01C then 21C; held_cnt 1 then 0; each byte gives one nextdata_n pulse.
//  2 E0 14, E0 F0 14 -> ctrl=1 after first event; events 114, 314; ctrl=0 after last.
//  3 1C,1C,1C with EMIT_REPEAT=1 -> 01C, 41C, 41C, held_cnt=1; with EMIT_REPEAT=0 only 01C.
//  4 58, F0 58, 58 -> caps 0->1 (stays 1 on break) ->0; repeated 58 while held does not toggle.
//  5 E1 14 77 E1 F0 14 F0 77 -> single event 17E, held_cnt=0, FSM back in IDLE.
//  6 DEPTH=4, ev_ready=0, 5 makes -> ev_count=4, ovf=1, head=first code.
//    Pop + push in same cycle at full -> count 4; clr mid-E0 -> next 1C yields 01C.

Source files
------------

// File: rtl/ps2_key_event_queue.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_event_queue
// Description : Decodes the PS/2 scan-code byte stream into make/break/repeat
//               events, tracks held keys, modifiers and locks, queues events.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_event_queue #(
  parameter int DEPTH       = 16,
  parameter int EMIT_REPEAT = 1,
  parameter int PAUSE_SKIP  = 7
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [7:0]               kb_data,
  input  logic                     kb_ready,
  output logic                     kb_nextdata_n,
  output logic [10:0]              ev_data,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic                     shift,
  output logic                     ctrl,
  output logic                     alt,
  output logic                     caps,
  output logic                     num,
  output logic                     scroll,
  output logic [8:0]               held_cnt
);

  localparam int              C_AW   = $clog2(DEPTH);
  localparam logic [C_AW:0]   c_full = (C_AW+1)'(DEPTH);
  localparam logic [7:0]      c_skip = 8'(PAUSE_SKIP);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_E0   = 3'd1,
    S_F0   = 3'd2,
    S_E0F0 = 3'd3,
    S_SKIP = 3'd4
  } state_t;

  state_t            r_state, w_nstate;
  logic              r_ack;
  logic [7:0]        r_skip_cnt;
  logic [255:0]      r_plain, r_e0tab;
  logic [8:0]        r_held;
  logic              r_caps, r_num, r_scroll, r_ovf;
  logic [10:0]       r_mem [DEPTH];
  logic [C_AW-1:0]   r_wr, r_rd;
  logic [C_AW:0]     r_count;

  logic              w_take, w_make, w_brk, w_e0, w_pause, w_skip_load, w_skip_dec;
  logic [7:0]        w_code;
  logic              w_bit, w_repeat, w_push, w_pop, w_full, w_push_ok, w_drop, w_lock_ok;
  logic [10:0]       w_ev;

  assign w_take = kb_ready & ~r_ack;

  always_comb begin
    w_nstate    = r_state;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    w_e0        = 1'b0;
    w_pause     = 1'b0;
    w_skip_load = 1'b0;
    w_skip_dec  = 1'b0;
    w_code      = kb_data;
    if (w_take) begin
      case (r_state)
        S_IDLE: begin
          case (kb_data)
            8'hE0: w_nstate = S_E0;
            8'hF0: w_nstate = S_F0;
            8'hE1: begin
              w_nstate    = S_SKIP;
              w_skip_load = 1'b1;
            end
            8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: w_nstate = S_IDLE;
            default: w_make = 1'b1;
          endcase
        end
        S_E0: begin
          case (kb_data)
            8'hF0: w_nstate = S_E0F0;
            8'hE0: w_nstate = S_E0;
            8'hE1, 8'hFA, 8'hAA: w_nstate = S_IDLE;
            default: begin
              w_make   = 1'b1;
              w_e0     = 1'b1;
              w_nstate = S_IDLE;
            end
          endcase
        end
        S_F0, S_E0F0: begin
          w_nstate = S_IDLE;
          if (kb_data != 8'hE0 && kb_data != 8'hF0 && kb_data != 8'hE1) begin
            w_brk = 1'b1;
            w_e0  = (r_state == S_E0F0);
          end
        end
        S_SKIP: begin
          // The Pause sequence carries no break; emit one synthetic make at its end
          if (r_skip_cnt <= 8'd1) begin
            w_make   = 1'b1;
            w_pause  = 1'b1;
            w_e0     = 1'b1;
            w_code   = 8'h7E;
            w_nstate = S_IDLE;
          end else begin
            w_skip_dec = 1'b1;
          end
        end
        default: w_nstate = S_IDLE;
      endcase
    end
  end

  assign w_bit     = w_e0 ? r_e0tab[w_code] : r_plain[w_code];
  assign w_repeat  = w_make & ~w_pause & w_bit;
  assign w_push    = (w_make & (~w_repeat | (EMIT_REPEAT != 0))) | w_brk;
  assign w_ev      = {w_repeat, w_brk, w_e0, w_code};
  assign w_lock_ok = w_make & ~w_repeat & ~w_e0;

  assign w_full    = (r_count == c_full);
  assign w_pop     = ev_ready & (r_count != '0);
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_ack      <= 1'b0;
      r_skip_cnt <= '0;
      r_plain    <= '0;
      r_e0tab    <= '0;
      r_held     <= '0;
      r_caps     <= 1'b0;
      r_num      <= 1'b0;
      r_scroll   <= 1'b0;
      r_ovf      <= 1'b0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_nstate;
      r_ack   <= w_take;
      if (w_skip_load)     r_skip_cnt <= c_skip;
      else if (w_skip_dec) r_skip_cnt <= r_skip_cnt - 8'd1;

      if (w_make & ~w_pause & ~w_bit) begin
        if (w_e0) r_e0tab[w_code] <= 1'b1;
        else      r_plain[w_code] <= 1'b1;
        r_held <= r_held + 9'd1;
      end else if (w_brk & w_bit) begin
        if (w_e0) r_e0tab[w_code] <= 1'b0;
        else      r_plain[w_code] <= 1'b0;
        r_held <= r_held - 9'd1;
      end

      if (w_lock_ok && w_code == 8'h58) r_caps   <= ~r_caps;
      if (w_lock_ok && w_code == 8'h77) r_num    <= ~r_num;
      if (w_lock_ok && w_code == 8'h7E) r_scroll <= ~r_scroll;

      // A drop in the same cycle as a clear request keeps the flag set
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;

      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop)     r_rd <= r_rd + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr] <= w_ev;
  end

  assign kb_nextdata_n = ~r_ack;
  assign ev_valid      = (r_count != '0);
  assign ev_data       = ev_valid ? r_mem[r_rd] : 11'd0;
  assign ev_count      = r_count;
  assign ovf           = r_ovf;
  assign held_cnt      = r_held;
  assign caps          = r_caps;
  assign num           = r_num;
  assign scroll        = r_scroll;
  assign shift         = r_plain[8'h12] | r_plain[8'h59];
  assign ctrl          = r_plain[8'h14] | r_e0tab[8'h14];
  assign alt           = r_plain[8'h11] | r_e0tab[8'h11];

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_event_queue
// Description : Directed bench; instance a is DEPTH=16/EMIT_REPEAT=1,
//               instance b is DEPTH=4/EMIT_REPEAT=0, both fed the same bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_event_queue;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [7:0]  kb_data = 8'h00;
  logic        kb_ready = 1'b0;
  logic        ev_ready_a = 1'b0, ev_ready_b = 1'b0, ovf_clr = 1'b0;

  logic        nd_a, nd_b, val_a, val_b, ovf_a, ovf_b;
  logic [10:0] dat_a, dat_b;
  logic [4:0]  cnt_a;
  logic [2:0]  cnt_b;
  logic        sh_a, ct_a, al_a, cp_a, nm_a, sc_a;
  logic        sh_b, ct_b, al_b, cp_b, nm_b, sc_b;
  logic [8:0]  held_a, held_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ps2_key_event_queue #(.DEPTH(16), .EMIT_REPEAT(1), .PAUSE_SKIP(7)) dut_a (
    .clk(clk), .clr(clr), .kb_data(kb_data), .kb_ready(kb_ready), .kb_nextdata_n(nd_a),
    .ev_data(dat_a), .ev_valid(val_a), .ev_ready(ev_ready_a), .ev_count(cnt_a),
    .ovf(ovf_a), .ovf_clr(ovf_clr), .shift(sh_a), .ctrl(ct_a), .alt(al_a),
    .caps(cp_a), .num(nm_a), .scroll(sc_a), .held_cnt(held_a));

  ps2_key_event_queue #(.DEPTH(4), .EMIT_REPEAT(0), .PAUSE_SKIP(7)) dut_b (
    .clk(clk), .clr(clr), .kb_data(kb_data), .kb_ready(kb_ready), .kb_nextdata_n(nd_b),
    .ev_data(dat_b), .ev_valid(val_b), .ev_ready(ev_ready_b), .ev_count(cnt_b),
    .ovf(ovf_b), .ovf_clr(ovf_clr), .shift(sh_b), .ctrl(ct_b), .alt(al_b),
    .caps(cp_b), .num(nm_b), .scroll(sc_b), .held_cnt(held_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte offered for one cycle; returns at the negedge after consumption
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    kb_data  = b;
    kb_ready = 1'b1;
    @(negedge clk);
    kb_ready = 1'b0;
    chk("nextdata_pulse", 32'({nd_a, nd_b}), 32'h0);
  endtask

  task automatic pop_a(input string tag, input logic [10:0] exp);
    chk({tag, "_valid"}, 32'(val_a), 32'h1);
    chk({tag, "_data"}, 32'(dat_a), 32'(exp));
    ev_ready_a = 1'b1;
    @(negedge clk);
    ev_ready_a = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    clr = 1'b0;
    // Reset state
    chk("rst_nextdata", 32'(nd_a), 32'h1);
    chk("rst_valid", 32'(val_a), 32'h0);
    chk("rst_count", 32'(cnt_a), 32'h0);
    chk("rst_held", 32'(held_a), 32'h0);
    chk("rst_flags", 32'({ovf_a, sh_a, ct_a, al_a, cp_a, nm_a, sc_a}), 32'h0);
    chk("rst_data", 32'(dat_a), 32'h0);

    // Plain make then break
    send_byte(8'h1C);
    chk("t1_held1", 32'(held_a), 32'h1);
    chk("t1_count1", 32'(cnt_a), 32'h1);
    pop_a("t1_make", 11'h01C);
    chk("t1_empty", 32'(val_a), 32'h0);
    send_byte(8'hF0);
    chk("t1_held_mid", 32'(held_a), 32'h1);
    send_byte(8'h1C);
    chk("t1_held0", 32'(held_a), 32'h0);
    pop_a("t1_break", 11'h21C);

    // Extended right ctrl
    send_byte(8'hE0);
    send_byte(8'h14);
    chk("t2_ctrl_on", 32'(ct_a), 32'h1);
    pop_a("t2_make", 11'h114);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h14);
    chk("t2_ctrl_off", 32'(ct_a), 32'h0);
    pop_a("t2_break", 11'h314);

    // Typematic repeat; instance b drops repeats
    do_reset();
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    chk("t3_held", 32'(held_a), 32'h1);
    chk("t3_count_a", 32'(cnt_a), 32'h3);
    chk("t3_count_b", 32'(cnt_b), 32'h1);
    chk("t3_head_b", 32'(dat_b), 32'h01C);
    pop_a("t3_ev0", 11'h01C);
    pop_a("t3_ev1", 11'h41C);
    pop_a("t3_ev2", 11'h41C);

    // Caps lock toggling
    do_reset();
    send_byte(8'h58);
    chk("t4_caps_on", 32'(cp_a), 32'h1);
    pop_a("t4_make", 11'h058);
    send_byte(8'h58);
    chk("t4_caps_rep", 32'(cp_a), 32'h1);
    pop_a("t4_rep", 11'h458);
    send_byte(8'hF0);
    send_byte(8'h58);
    chk("t4_caps_brk", 32'(cp_a), 32'h1);
    pop_a("t4_break", 11'h258);
    send_byte(8'h58);
    chk("t4_caps_off", 32'(cp_a), 32'h0);
    pop_a("t4_make2", 11'h058);

    // Pause sequence
    do_reset();
    send_byte(8'hE1);
    send_byte(8'h14);
    send_byte(8'h77);
    send_byte(8'hE1);
    send_byte(8'hF0);
    send_byte(8'h14);
    send_byte(8'hF0);
    send_byte(8'h77);
    chk("t5_count", 32'(cnt_a), 32'h1);
    chk("t5_held", 32'(held_a), 32'h0);
    chk("t5_locks", 32'({cp_a, nm_a, sc_a, ct_a}), 32'h0);
    pop_a("t5_pause", 11'h17E);
    send_byte(8'h1C);
    pop_a("t5_idle", 11'h01C);

    // Overflow on the DEPTH=4 instance
    do_reset();
    send_byte(8'h15);
    send_byte(8'h16);
    send_byte(8'h1A);
    send_byte(8'h1B);
    chk("t6_ovf_not_yet", 32'(ovf_b), 32'h0);
    send_byte(8'h1C);
    chk("t6_count", 32'(cnt_b), 32'h4);
    chk("t6_ovf", 32'(ovf_b), 32'h1);
    chk("t6_head", 32'(dat_b), 32'h015);
    chk("t6_held", 32'(held_b), 32'h5);
    @(negedge clk);
    kb_data    = 8'h1D;
    kb_ready   = 1'b1;
    ev_ready_b = 1'b1;
    @(negedge clk);
    kb_ready   = 1'b0;
    ev_ready_b = 1'b0;
    chk("t6_poppush_count", 32'(cnt_b), 32'h4);
    chk("t6_poppush_head", 32'(dat_b), 32'h016);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t6_ovf_clr", 32'(ovf_b), 32'h0);
    @(negedge clk);
    kb_data  = 8'h21;
    kb_ready = 1'b1;
    ovf_clr  = 1'b1;
    @(negedge clk);
    kb_ready = 1'b0;
    ovf_clr  = 1'b0;
    chk("t6_set_wins", 32'(ovf_b), 32'h1);
    chk("t6_count_full", 32'(cnt_b), 32'h4);

    // Reset in the middle of an E0 prefix
    do_reset();
    send_byte(8'hE0);
    do_reset();
    chk("t6_clr_empty", 32'(cnt_a), 32'h0);
    send_byte(8'h1C);
    chk("t6_clr_count", 32'(cnt_a), 32'h1);
    pop_a("t6_clr_ev", 11'h01C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
